// File: rtl/ctrl_unit_multicycle.sv
// Main control FSM for the multicycle MIPS datapath (add/sub/and, addi, lw, sw, beq, bne, j)
// with invalid-opcode and overflow exception sequencing. The SP reset constant lives in the datapath.
module ctrl_unit_multicycle #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Overflow_ULA,
  input  logic       Igual_ULA,
  output logic       PCWrite,
  output logic [2:0] PCSource,
  output logic [1:0] IorD,
  output logic [1:0] ExceptionAddress,
  output logic       MemReadOrWrite,
  output logic       IRWrite,
  output logic       MemDataRegLoad,
  output logic       A_w,
  output logic       B_w,
  output logic       AluOutWrite,
  output logic       EPCWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [5:0] state_out
);

  typedef enum logic [5:0] {
    S_RESET     = 6'd0,
    S_FETCH     = 6'd1,
    S_DECODE    = 6'd2,
    S_EXEC_R    = 6'd3,
    S_WB_R      = 6'd4,
    S_EXEC_I    = 6'd5,
    S_WB_I      = 6'd6,
    S_ADDR      = 6'd7,
    S_MEM_RD    = 6'd8,
    S_WB_LW     = 6'd9,
    S_MEM_WR    = 6'd10,
    S_BRANCH    = 6'd11,
    S_JUMP      = 6'd12,
    S_EXC_EPC   = 6'd13,
    S_EXC_OVF   = 6'd14,
    S_EXC_RD    = 6'd15,
    S_EXC_JMP   = 6'd16
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

  state_t     state_r;
  logic [1:0] wcnt_r;
  logic [1:0] exc_code_r;
  logic       last_s;

  // Multi-cycle memory states finish when the wait counter reaches MEM_WAIT
  assign last_s = (wcnt_r == WAIT_LAST);

  // State, wait counter and latched exception code
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_RESET;
      wcnt_r     <= 2'd0;
      exc_code_r <= 2'd0;
    end else begin
      wcnt_r <= 2'd0;
      case (state_r)
        S_RESET:  state_r <= S_FETCH;
        S_FETCH: begin
          if (last_s) state_r <= S_DECODE;
          else        wcnt_r  <= wcnt_r + 2'd1;
        end
        S_DECODE: begin
          case (opcode)
            OP_R:         state_r <= S_EXEC_R;
            OP_ADDI:      state_r <= S_EXEC_I;
            OP_LW, OP_SW: state_r <= S_ADDR;
            OP_BEQ, OP_BNE: state_r <= S_BRANCH;
            OP_J:         state_r <= S_JUMP;
            default:      state_r <= S_EXC_EPC;
          endcase
        end
        S_EXEC_R: begin
          case (funct)
            FN_ADD, FN_SUB: state_r <= Overflow_ULA ? S_EXC_OVF : S_WB_R;
            FN_AND:         state_r <= S_WB_R;
            default:        state_r <= S_EXC_EPC;
          endcase
        end
        S_EXEC_I: state_r <= Overflow_ULA ? S_EXC_OVF : S_WB_I;
        S_ADDR:   state_r <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (last_s) state_r <= S_WB_LW;
          else        wcnt_r  <= wcnt_r + 2'd1;
        end
        S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP: state_r <= S_FETCH;
        S_EXC_EPC: begin
          state_r    <= S_EXC_RD;
          exc_code_r <= 2'b01;
        end
        S_EXC_OVF: begin
          state_r    <= S_EXC_RD;
          exc_code_r <= 2'b10;
        end
        S_EXC_RD: begin
          if (last_s) state_r <= S_EXC_JMP;
          else        wcnt_r  <= wcnt_r + 2'd1;
        end
        S_EXC_JMP: begin
          state_r    <= S_FETCH;
          exc_code_r <= 2'b00;
        end
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the datapath controls; only the branch PCWrite looks at a flag
  always_comb begin
    PCWrite          = 1'b0;
    PCSource         = 3'b000;
    IorD             = 2'b00;
    ExceptionAddress = 2'b00;
    MemReadOrWrite   = 1'b0;
    IRWrite          = 1'b0;
    MemDataRegLoad   = 1'b0;
    A_w              = 1'b0;
    B_w              = 1'b0;
    AluOutWrite      = 1'b0;
    EPCWrite         = 1'b0;
    RegWrite         = 1'b0;
    RegDst           = 2'b00;
    MemToReg         = 3'b000;
    AluSrcA          = 1'b0;
    AluSrcB          = 2'b00;
    AluOp            = 3'b000;
    state_out        = state_r;
    case (state_r)
      S_FETCH: begin
        AluSrcB = 2'b01;
        AluOp   = 3'b001;
        IRWrite = last_s;
        PCWrite = last_s;
      end
      S_DECODE: begin
        A_w         = 1'b1;
        B_w         = 1'b1;
        AluSrcB     = 2'b11;
        AluOp       = 3'b001;
        AluOutWrite = 1'b1;
      end
      S_EXEC_R: begin
        AluSrcA = 1'b1;
        case (funct)
          FN_ADD: begin AluOp = 3'b001; AluOutWrite = 1'b1; end
          FN_SUB: begin AluOp = 3'b010; AluOutWrite = 1'b1; end
          FN_AND: begin AluOp = 3'b011; AluOutWrite = 1'b1; end
          default: AluOp = 3'b000;
        endcase
      end
      S_WB_R: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        AluSrcA     = 1'b1;
        AluSrcB     = 2'b10;
        AluOp       = 3'b001;
        AluOutWrite = 1'b1;
      end
      S_WB_I:   RegWrite = 1'b1;
      S_MEM_RD: begin
        IorD           = 2'b01;
        MemDataRegLoad = last_s;
      end
      S_WB_LW: begin
        MemToReg = 3'b001;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD           = 2'b01;
        MemReadOrWrite = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA  = 1'b1;
        AluOp    = 3'b111;
        PCSource = 3'b001;
        if (opcode == OP_BEQ) PCWrite = Igual_ULA;
        else if (opcode == OP_BNE) PCWrite = ~Igual_ULA;
        else PCWrite = 1'b0;
      end
      S_JUMP: begin
        PCSource = 3'b010;
        PCWrite  = 1'b1;
      end
      S_EXC_EPC, S_EXC_OVF: begin
        AluSrcB  = 2'b01;
        AluOp    = 3'b010;
        EPCWrite = 1'b1;
      end
      S_EXC_RD: begin
        IorD             = 2'b10;
        ExceptionAddress = exc_code_r;
        MemDataRegLoad   = last_s;
      end
      S_EXC_JMP: begin
        PCSource = 3'b011;
        PCWrite  = 1'b1;
      end
      default: begin
        RegDst   = 2'b10;
        MemToReg = 3'b010;
        RegWrite = 1'b1;
      end
    endcase
  end

endmodule
